// File: rtl/mul_add_pkg.sv
// mul_add_pkg: shared minicalc definitions; FSM encoding and sizing helpers for mul_add.
package mul_add_pkg;
   localparam int STATE_W = 2;
   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
   function automatic int cnt_width(input int bits);
      return bits > 1 ? $clog2(bits) : 1;
   endfunction
endpackage

// File: rtl/mul_add_if.sv
// mul_add_if: start/busy/done handshake bundle with operands and result for mul_add.
interface mul_add_if #(parameter int BITS = 4);
   logic              start;
   logic [BITS-1:0]   a;
   logic [BITS-1:0]   b;
   logic [BITS-1:0]   c;
   logic              busy;
   logic              done;
   logic [2*BITS-1:0] result;
   modport master (output start, a, b, c, input busy, done, result);
   modport slave  (input start, a, b, c, output busy, done, result);
endinterface

// File: rtl/mul_add.sv
// mul_add: sequential unsigned a*b+c, one multiplier bit per clock under a start/busy/done handshake.
module mul_add
   import mul_add_pkg::*;
#(
   parameter int BITS = 4
) (
   input logic       clk,
   input logic       rst,
   mul_add_if.slave  bus
);
   localparam int CW = cnt_width(BITS);
   localparam int RW = 2 * BITS;
   state_e          state_q, state_d;
   logic [BITS-1:0] a_q, a_d, b_q, b_d;
   logic [RW-1:0]   acc_q, acc_d, result_q, result_d, sum;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last;
   always_comb begin
      last     = cnt_q == CW'(BITS - 1);
      sum      = acc_q + (b_q[cnt_q] ? ({{BITS{1'b0}}, a_q} << cnt_q) : '0);
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (state_q == IDLE && bus.start) begin
         a_d     = bus.a;
         b_d     = bus.b;
         acc_d   = {{BITS{1'b0}}, bus.c};
         cnt_d   = '0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         acc_d    = sum;
         cnt_d    = cnt_q + 1'b1;
         state_d  = last ? DONE : RUN;
         // result is published on the same edge that enters DONE, so done and result align
         result_d = last ? sum : result_q;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end
   assign bus.busy   = state_q == RUN;
   assign bus.done   = state_q == DONE;
   assign bus.result = result_q;
endmodule

// File: tb/tb_mul_add.sv
// tb_mul_add: table, random, divide round-trip and handshake corner checks for mul_add (BITS=4).
module tb_mul_add;
   localparam int BITS = 4;
   typedef struct {
      int a;
      int b;
      int c;
      int exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t vt[5];
   always #5 clk = ~clk;
   mul_add_if #(.BITS(BITS)) bus ();
   mul_add #(.BITS(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   task automatic do_op(input int a, input int b, input int c, input string name);
      int exp = a * b + c;
      int busy_cnt = 0;
      int cyc = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = BITS'(a);
      bus.b = BITS'(b);
      bus.c = BITS'(c);
      @(negedge clk);
      bus.start = 1'b0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) busy_cnt++;
         bus.a = BITS'($urandom);
         bus.b = BITS'($urandom);
         bus.c = BITS'($urandom);
         @(negedge clk);
         cyc++;
      end
      chk({name, " done seen"}, 32'(cyc < 20), 1);
      chk({name, " busy cycles"}, busy_cnt, BITS);
      chk({name, " busy with done"}, bus.busy, 0);
      chk({name, " result"}, bus.result, exp);
      bus.start = 1'b1;
      bus.a = BITS'($urandom);
      bus.b = BITS'($urandom);
      bus.c = BITS'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      chk({name, " done width"}, bus.done, 0);
      chk({name, " start in DONE ignored"}, bus.busy, 0);
      chk({name, " result held"}, bus.result, exp);
   endtask
   initial begin
      int prev, ndone, seen;
      vt[0] = '{a: 7,  b: 9,  c: 0,  exp: 63};
      vt[1] = '{a: 15, b: 15, c: 15, exp: 240};
      vt[2] = '{a: 3,  b: 4,  c: 1,  exp: 13};
      vt[3] = '{a: 0,  b: 11, c: 5,  exp: 5};
      vt[4] = '{a: 0,  b: 0,  c: 0,  exp: 0};
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      chk("reset result", bus.result, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_op(vt[i].a, vt[i].b, vt[i].c, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d table", i), bus.result, vt[i].exp);
      end
      for (int i = 0; i < 30; i++)
         do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      for (int dd = 0; dd < 16; dd++)
         for (int dv = 1; dv < 16; dv++)
            do_op(dd / dv, dv, dd % dv, $sformatf("div %0d/%0d", dd, dv));
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 4'd2;
      bus.b = 4'd3;
      bus.c = 4'd0;
      prev = -1;
      ndone = 0;
      for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            chk("held start result", bus.result, 6);
            if (prev >= 0) chk("held start period", cyc - prev, BITS + 2);
            prev = cyc;
            ndone++;
         end
      end
      chk("held start ops", ndone, 3);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 4'd5;
      bus.b = 4'd5;
      bus.c = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid reset busy", bus.busy, 0);
      chk("mid reset done", bus.done, 0);
      chk("mid reset result", bus.result, 0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      chk("no activity after reset", seen, 0);
      do_op(5, 5, 1, "after reset");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mul_add.md
# mul_add

Sequential unsigned multiply-add unit for the minicalc datapath: computes `result = a * b + c` by iterative shift-and-add, one multiplier bit per clock. It is the inverse of the combinational divider. Feeding it a quotient, the divider value and the modulo reconstructs the original dividend, which is how the board self-checks its divide operation. It runs under a start/busy/done handshake so wider `BITS` values close timing without a combinational array multiplier.

## Interface
Parameters:
- `BITS`, default 4: operand width; result width is `2*BITS`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  BITS  multiplicand (unsigned).
- `b`  input  BITS  multiplier (unsigned).
- `c`  input  BITS  addend (unsigned), zero-extended.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse when `result` becomes valid.
- `result`  output  2*BITS  `a*b + c`; held until the next accepted start.

## Operation
- States:
  - IDLE: `busy=0`, `done=0`.
  - RUN: `busy=1`, `done=0`.
  - DONE: `busy=0`, `done=1`.
- IDLE with `start=1`:
  - latch `a`, `b`;
  - initialize accumulator to `{BITS'b0, c}` and bit counter to 0;
  - go to RUN.
- IDLE with `start=0`: stay in IDLE; `result` unchanged.
- RUN, each cycle:
  - if `b_latched[cnt]`, add `a_latched << cnt` to the accumulator;
  - increment `cnt`;
  - after the iteration with `cnt == BITS-1`, go to DONE.
- DONE: copy the accumulator to `result`, then go to IDLE next cycle.
  - `start` in DONE is ignored.
  - Back-to-back operation therefore needs `start` held or re-asserted in IDLE.
- `start`, `a`, `b` and `c` are ignored outside IDLE. Operand changes mid-operation have no effect.
- Arithmetic width:
  - accumulator is `2*BITS` bits and cannot overflow, since max `(2^B-1)^2 + (2^B-1) = 2^(2B) - 2^B`;
  - no carry-out or overflow flag.
- `a=0` or `b=0`: all BITS iterations still run; `result = c`. Latency is fixed, with no early termination.

## Timing
- Reset (synchronous, `rst=1` at an edge), regardless of current state:
  - state becomes IDLE;
  - `busy=0`, `done=0`, `result=0`;
  - accumulator and counter are cleared.
- Reset mid-RUN aborts the operation; no `done` pulse is produced.
- `start` sampled high in IDLE at edge T:
  - RUN from edge T through edge T+BITS;
  - `busy` high for exactly BITS cycles, edges T..T+BITS-1;
  - `done` high for exactly one cycle, after edge T+BITS;
  - `result` updates at edge T+BITS;
  - IDLE after edge T+BITS+1.
- Throughput: one operation per BITS+2 cycles at best.
- `busy` and `done` are never high together.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- State encoding (IDLE/RUN/DONE, 2 bits) lives as localparams in the shared minicalc definitions header. minicalc and this block use the same header.
- No sub-module. Datapath (shifted add, counter) and FSM share one always block plus output assigns; it is small enough to stay flat.
- `cnt` width is `$clog2(BITS)` bits, minimum 1.

## Test plan
- BITS=4, `a=7 b=9 c=0`, start pulsed at T -> `busy` high 4 cycles; `done` one cycle after edge T+4; `result=63` (0x3F).
- `a=15 b=15 c=15` -> `result=240` (0xF0), no overflow.
- Divide round trip: 13/4 gives q=3, r=1; feed `a=3 b=4 c=1` -> `result=13`. Sweep all 4-bit dividends and nonzero divider values against the divider and check reconstruction.
- `a=0 b=11 c=5` -> `result=5`, still a 4-cycle `busy`.
- Handshake edges:
  - `start` held high continuously with `a=2 b=3 c=0` -> `result=6`, operations every 6 cycles;
  - operands changed during RUN -> result unaffected;
  - `start` during DONE -> ignored.
- Reset mid-operation: `rst` at second RUN cycle -> next cycle `busy=0 done=0 result=0`, no `done` pulse. A fresh start afterward computes correctly.
